easyaxi_seq_ctrl: RTL and testbench

- Sequencer for the EASYAXI master's level-held command interface (rd_en/rd_done, wr_en/wr_done).
- Replaces the hand-timed enables in the top-level bench with a programmable engine.
- Issues a programmed number of read and write bursts in a selectable order and counts completions.
- Watchdog flags any command whose done never arrives; sits between a config/start source and EASYAXI_TOP.

---
 rtl/easyaxi_seq_pkg.sv | 47 ++++
 rtl/easyaxi_seq_wdog.sv | 33 +++
 rtl/easyaxi_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_easyaxi_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easyaxi_seq_pkg.sv
`default_nettype none
// ============================================================================
// easyaxi_seq_pkg : state and mode encodings shared by the EASYAXI sequencer
// Revision: 1.0
// ============================================================================
package easyaxi_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEL    = 3'd1;
    localparam logic [2:0] ST_RD_ISS = 3'd2;
    localparam logic [2:0] ST_RD_REL = 3'd3;
    localparam logic [2:0] ST_WR_ISS = 3'd4;
    localparam logic [2:0] ST_WR_REL = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [1:0] MODE_RD_FIRST = 2'b00;
    localparam logic [1:0] MODE_WR_FIRST = 2'b01;
    localparam logic [1:0] MODE_ALT_RD   = 2'b10;
    localparam logic [1:0] MODE_ALT_WR   = 2'b11;

    // An exhausted side always yields to the other; otherwise the mode decides.
    function automatic logic pick_read(
        input logic [1:0] mode,
        input logic       rd_left,
        input logic       wr_left,
        input logic       last_wr
    );
        logic r;
        r = 1'b1;
        if (!wr_left) begin
            r = 1'b1;
        end else if (!rd_left) begin
            r = 1'b0;
        end else begin
            case (mode)
                MODE_RD_FIRST: r = 1'b1;
                MODE_WR_FIRST: r = 1'b0;
                MODE_ALT_RD:   r = last_wr;
                MODE_ALT_WR:   r = last_wr;
            endcase
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/easyaxi_seq_wdog.sv
`default_nettype none
// ============================================================================
// easyaxi_seq_wdog : outstanding-command watchdog, flags expiry at TIMEOUT_CYC
// Revision: 1.0
// ============================================================================
module easyaxi_seq_wdog #(
    parameter int TO_W        = 11,
    parameter int TIMEOUT_CYC = 1500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TO_W-1:0] C_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // Asserted in the last cycle of the window so the enable has been high TIMEOUT_CYC cycles.
    assign expired = inc && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/easyaxi_seq_ctrl.sv
`default_nettype none
// ============================================================================
// easyaxi_seq_ctrl : programmable read/write command sequencer for EASYAXI_TOP
// Revision: 1.0
// ============================================================================
module easyaxi_seq_ctrl
    import easyaxi_seq_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TO_W        = 11,
    parameter int TIMEOUT_CYC = 1500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rd_num,
    input  logic [CNT_W-1:0] wr_num,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             rd_en,
    input  logic             rd_done,
    output logic             wr_en,
    input  logic             wr_done
);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_rd_num;
    logic [CNT_W-1:0] r_wr_num;
    logic [CNT_W-1:0] r_rd_cnt;
    logic [CNT_W-1:0] r_wr_cnt;
    logic [1:0]       r_mode;
    logic             r_last_wr;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_rd_en;
    logic             r_wr_en;

    logic w_issuing;
    logic w_expired;
    logic w_rd_left;
    logic w_wr_left;

    assign w_issuing = (r_state == ST_RD_ISS) || (r_state == ST_WR_ISS);
    assign w_rd_left = (r_rd_cnt != r_rd_num);
    assign w_wr_left = (r_wr_cnt != r_wr_num);

    easyaxi_seq_wdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!w_issuing),
        .inc     (w_issuing),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rd_num  <= '0;
            r_wr_num  <= '0;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_mode    <= MODE_RD_FIRST;
            r_last_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rd_num  <= rd_num;
                        r_wr_num  <= wr_num;
                        r_mode    <= mode;
                        r_rd_cnt  <= '0;
                        r_wr_cnt  <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        // Seed "last issued" as the opposite of the first alternating pick.
                        r_last_wr <= (mode != MODE_ALT_WR);
                        r_state   <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (!w_rd_left && !w_wr_left) begin
                        r_state <= ST_FIN;
                    end else if (pick_read(r_mode, w_rd_left, w_wr_left, r_last_wr)) begin
                        r_rd_en   <= 1'b1;
                        r_last_wr <= 1'b0;
                        r_state   <= ST_RD_ISS;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_last_wr <= 1'b1;
                        r_state   <= ST_WR_ISS;
                    end
                end
                ST_RD_ISS: begin
                    if (rd_done) begin
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        r_rd_en  <= 1'b0;
                        r_state  <= ST_RD_REL;
                    end else if (w_expired) begin
                        r_rd_en  <= 1'b0;
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_ERR;
                    end
                end
                ST_RD_REL: begin
                    if (!rd_done) begin
                        r_state <= ST_SEL;
                    end
                end
                ST_WR_ISS: begin
                    if (wr_done) begin
                        r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        r_wr_en  <= 1'b0;
                        r_state  <= ST_WR_REL;
                    end else if (w_expired) begin
                        r_wr_en  <= 1'b0;
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_ERR;
                    end
                end
                ST_WR_REL: begin
                    if (!wr_done) begin
                        r_state <= ST_SEL;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
    assign rd_en  = r_rd_en;
    assign wr_en  = r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_easyaxi_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_easyaxi_seq_ctrl : directed self-checking bench for easyaxi_seq_ctrl
// Revision: 1.0
// ============================================================================
module tb_easyaxi_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rd_num;
    logic [7:0] wr_num;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rd_cnt;
    logic [7:0] wr_cnt;
    logic       rd_en;
    logic       rd_done;
    logic       wr_en;
    logic       wr_done;

    int n_checks = 0;
    int n_fail   = 0;

    bit resp_on    = 1'b0;
    int resp_delay = 5;
    int resp_hold  = 4;

    bit ev_q[$];
    bit overlap_seen = 1'b0;

    always #5 clk = ~clk;

    easyaxi_seq_ctrl #(
        .CNT_W       (8),
        .TO_W        (11),
        .TIMEOUT_CYC (1500)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rd_num  (rd_num),
        .wr_num  (wr_num),
        .mode    (mode),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_cnt  (rd_cnt),
        .wr_cnt  (wr_cnt),
        .rd_en   (rd_en),
        .rd_done (rd_done),
        .wr_en   (wr_en),
        .wr_done (wr_done)
    );

    // Master model: done rises resp_delay cycles after the enable, held resp_hold cycles.
    initial begin
        rd_done = 1'b0;
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_on && rd_en) begin
                repeat (resp_delay - 1) @(negedge clk);
                rd_done = 1'b1;
                repeat (resp_hold) @(negedge clk);
                rd_done = 1'b0;
            end else if (resp_on && wr_en) begin
                repeat (resp_delay - 1) @(negedge clk);
                wr_done = 1'b1;
                repeat (resp_hold) @(negedge clk);
                wr_done = 1'b0;
            end
        end
    end

    // Enable rise log (0 = read, 1 = write) and overlap detector.
    initial begin
        bit prev_rd;
        bit prev_wr;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_en === 1'b1 && !prev_rd) ev_q.push_back(1'b0);
            if (wr_en === 1'b1 && !prev_wr) ev_q.push_back(1'b1);
            if (rd_en === 1'b1 && wr_en === 1'b1) overlap_seen = 1'b1;
            prev_rd = (rd_en === 1'b1);
            prev_wr = (wr_en === 1'b1);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_seq(input string tag, input int rn, input int wn,
                           input logic [1:0] m, input string exp_order, input bit poke);
        int    base;
        int    cyc;
        int    done_n;
        bit    fin;
        string obs;
        base   = ev_q.size();
        rd_num = 8'(rn);
        wr_num = 8'(wn);
        mode   = m;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, int'(busy), 1);
        check({tag, "_err_cleared"}, int'(err), 0);
        cyc    = 0;
        done_n = 0;
        fin    = 1'b0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (done) done_n++;
            if (poke && cyc == 10) begin
                rd_num = 8'd7;
                wr_num = 8'd7;
                mode   = 2'b01;
                start  = 1'b1;
            end else begin
                start  = 1'b0;
                rd_num = 8'(rn);
                wr_num = 8'(wn);
                mode   = m;
            end
            if (!busy) fin = 1'b1;
        end
        start = 1'b0;
        check({tag, "_finished"}, int'(fin), 1);
        repeat (3) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check({tag, "_done_pulses"}, done_n, 1);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_rd_cnt"}, int'(rd_cnt), rn);
        check({tag, "_wr_cnt"}, int'(wr_cnt), wn);
        check({tag, "_overlap"}, int'(overlap_seen), 0);
        obs = "";
        for (int i = base; i < ev_q.size(); i++) obs = {obs, ev_q[i] ? "W" : "R"};
        n_checks++;
        assert (obs == exp_order) else begin
            n_fail++;
            $error("FAIL %s_order: observed %s expected %s", tag, obs, exp_order);
        end
    endtask

    initial begin
        int hi;
        int w;
        int dn;
        rst    = 1'b1;
        start  = 1'b0;
        rd_num = 8'd0;
        wr_num = 8'd0;
        mode   = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_rd_en", int'(rd_en), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_rd_cnt", int'(rd_cnt), 0);
        check("rst_wr_cnt", int'(wr_cnt), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        resp_on    = 1'b1;
        resp_delay = 5;
        resp_hold  = 4;
        run_seq("t1_rrw", 2, 1, 2'b00, "RRW", 1'b1);
        run_seq("t2_alt_rd", 3, 3, 2'b10, "RWRWRW", 1'b0);
        run_seq("t3_alt_wr", 3, 1, 2'b11, "WRRR", 1'b0);
        run_seq("t4_wr_first", 1, 2, 2'b01, "WWR", 1'b0);

        // Empty sequence: SEL straight to FIN, done three cycles after start.
        rd_num = 8'd0;
        wr_num = 8'd0;
        mode   = 2'b00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_c1_busy", int'(busy), 1);
        check("zero_c1_done", int'(done), 0);
        @(negedge clk);
        check("zero_c2_done", int'(done), 0);
        check("zero_c2_en", int'(rd_en | wr_en), 0);
        @(negedge clk);
        check("zero_c3_done", int'(done), 1);
        check("zero_c3_busy", int'(busy), 0);
        check("zero_c3_en", int'(rd_en | wr_en), 0);
        @(negedge clk);
        check("zero_c4_done", int'(done), 0);

        // Watchdog: read never completes.
        resp_on = 1'b0;
        repeat (2) @(negedge clk);
        rd_num = 8'd1;
        wr_num = 8'd0;
        mode   = 2'b00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!rd_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        hi = 0;
        dn = 0;
        while (rd_en && hi < 2000) begin
            hi++;
            if (done) dn++;
            @(negedge clk);
        end
        check("to_rd_en_cycles", hi, 1500);
        check("to_err", int'(err), 1);
        check("to_busy", int'(busy), 0);
        repeat (3) begin
            if (done) dn++;
            @(negedge clk);
        end
        check("to_no_done", dn, 0);
        check("to_err_sticky", int'(err), 1);
        check("to_rd_cnt", int'(rd_cnt), 0);

        resp_on = 1'b1;
        run_seq("t5_after_err", 1, 1, 2'b11, "WR", 1'b0);

        // Reset in the middle of a read issue.
        resp_on = 1'b0;
        repeat (2) @(negedge clk);
        rd_num = 8'd2;
        wr_num = 8'd0;
        mode   = 2'b00;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!rd_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("rst_mid_rd_en_seen", int'(rd_en), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rd_en", int'(rd_en), 0);
        check("rst_mid_wr_en", int'(wr_en), 0);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_done_after", int'(done), 0);

        resp_on = 1'b1;
        run_seq("t6_post_rst", 1, 1, 2'b00, "RW", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
